relay_station_n: RTL and testbench
==================================

RELAY_STATION_N -- requirements
Module: relay_station_n

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, number of storage entries; legal range >= 2, non-power-of-two allowed.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-1, occupancy at or above which afull_s asserts; legal range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; one clock, asynchronous and active-high.
REQ-006 SHALL have port flush, input, 1, synchronous discard of all stored entries.
REQ-007 SHALL have port ready_s, output, 1, slave-side ready (registered).
REQ-008 SHALL have port valid_s, input, 1, slave-side valid.
REQ-009 SHALL have port data_s, input, DATA_WIDTH, slave-side payload.
REQ-010 SHALL have port ready_m, input, 1, master-side ready.
REQ-011 SHALL have port valid_m, output, 1, master-side valid (registered).
REQ-012 SHALL have port data_m, output, DATA_WIDTH, master-side payload, head of buffer.
REQ-013 SHALL have port afull_s, output, 1, registered almost-full flag.

Function
REQ-014 SHALL define write = valid_s && ready_s and read = valid_m && ready_m; transfer only on these handshakes.
REQ-015 SHALL keep occupancy count in $clog2(DEPTH+1) bits; count_next = count + write - read.
REQ-016 SHALL advance wr_ptr on write and rd_ptr on read, each wrapping from DEPTH-1 to 0.
REQ-017 SHALL register ready_s = (count_next != DEPTH), valid_m = (count_next != 0), afull_s = (count_next >= AFULL_THRESH).
REQ-018 SHALL have no combinational path ready_m->ready_s or valid_s->valid_m.
REQ-019 SHALL present data accepted in cycle N on data_m with valid_m=1 in cycle N+1 when empty (latency 1).
REQ-020 SHALL sustain one transfer per cycle while ready_m=1 and valid_s=1, any occupancy 1..DEPTH-1.
REQ-021 SHALL hold valid_m and data_m stable while valid_m=1 and ready_m=0.
REQ-022 Full: ready_s=0 once count=DEPTH; a read when full SHALL raise ready_s next cycle.
REQ-023 Simultaneous write and read at count=1 SHALL keep valid_m=1 and present the new word next cycle.
REQ-024 SHALL emit words in acceptance order, none lost or duplicated outside flush.
REQ-025 flush=1 SHALL set count/pointers to 0, valid_m=0, ready_s=1, afull_s=0 next cycle; handshakes in the flush cycle are discarded; flush has priority over write/read.
REQ-026 data_m SHALL be don't-care while valid_m=0; storage is not reset.

Reset
REQ-027 rst=1 SHALL immediately, without clk, force ready_s=1, valid_m=0, afull_s=0, count=0, wr_ptr=rd_ptr=0.
REQ-028 Reset asserted mid-transfer SHALL discard all contents; first handshake after deassertion behaves as from empty.

Configuration
REQ-029 Macro RELAY_STATION_N_LEVEL_EN SHALL, when defined, add output port level, $clog2(DEPTH+1) bits, registered copy of count (reset 0, 0 after flush).
REQ-030 Without RELAY_STATION_N_LEVEL_EN, port level SHALL be absent and all other behaviour identical.

Verification (DATA_WIDTH=8, DEPTH=4, AFULL_THRESH=3)
REQ-031 Single word: valid_s=1, data_s=0xA5 one cycle, ready_m=1 -> next cycle valid_m=1, data_m=0xA5; cycle after valid_m=0.
REQ-032 Fill: ready_m=0, write 0x01..0x04 -> afull_s=1 after 3rd, ready_s=0 after 4th, level=4; 5th word not accepted.
REQ-033 Drain full: then ready_m=1 -> data_m 0x01,0x02,0x03,0x04 on consecutive cycles; ready_s=1 one cycle after first read.
REQ-034 Streaming: valid_s=ready_m=1 for 20 cycles, data_s=0..19 -> data_m 0..19 in order, one per cycle, no bubbles.
REQ-035 Flush: 2 words stored, flush=1 with valid_s=1, data_s=0x77 -> next cycle valid_m=0, level=0, ready_s=1; 0x77 never appears.
REQ-036 Async reset: rst pulsed between clk edges with 3 words stored -> valid_m=0, ready_s=1, afull_s=0 before next edge.

Source files
------------

// File: rtl/relay_station_n.sv
// relay_station_n: registered valid/ready relay buffer of DEPTH entries.
// Define RELAY_STATION_N_LEVEL_EN to add the registered occupancy port 'level'.
module relay_station_n #(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 2,
   parameter int AFULL_THRESH = DEPTH - 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   output logic                  ready_s,
   input  logic                  valid_s,
   input  logic [DATA_WIDTH-1:0] data_s,
   input  logic                  ready_m,
   output logic                  valid_m,
   output logic [DATA_WIDTH-1:0] data_m,
   output logic                  afull_s
`ifdef RELAY_STATION_N_LEVEL_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] C_AFULL = CW'(AFULL_THRESH);
   localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic          r_ready_s;
   logic          r_valid_m;
   logic          r_afull_s;

   logic          w_wr;
   logic          w_rd;
   logic [CW-1:0] w_count_nxt;
   logic [PW-1:0] w_wr_ptr_inc;
   logic [PW-1:0] w_rd_ptr_inc;

   assign w_wr = valid_s & r_ready_s;
   assign w_rd = r_valid_m & ready_m;

   // Occupancy after this cycle's handshakes; drives all registered flags.
   always_comb begin
      w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);
   end

   // Pointer increments wrap at DEPTH-1 so non-power-of-two depths work.
   always_comb begin
      w_wr_ptr_inc = (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + 1'b1;
      w_rd_ptr_inc = (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + 1'b1;
   end

   // Control state: count, pointers and registered handshake flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count   <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_ready_s <= 1'b1;
         r_valid_m <= 1'b0;
         r_afull_s <= 1'b0;
      end else if (flush) begin
         r_count   <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_ready_s <= 1'b1;
         r_valid_m <= 1'b0;
         r_afull_s <= 1'b0;
      end else begin
         r_count   <= w_count_nxt;
         if (w_wr) begin
            r_wr_ptr <= w_wr_ptr_inc;
         end
         if (w_rd) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
         r_ready_s <= (w_count_nxt != C_FULL);
         r_valid_m <= (w_count_nxt != '0);
         r_afull_s <= (w_count_nxt >= C_AFULL);
      end
   end

   // Payload storage is never reset; only accepted, non-flushed words land.
   always_ff @(posedge clk) begin
      if (w_wr && !flush && !rst) begin
         r_mem[r_wr_ptr] <= data_s;
      end
   end

   assign ready_s = r_ready_s;
   assign valid_m = r_valid_m;
   assign afull_s = r_afull_s;
   assign data_m  = r_mem[r_rd_ptr];

`ifdef RELAY_STATION_N_LEVEL_EN
   assign level = r_count;
`endif

endmodule

// File: tb/tb_relay_station_n.sv
// tb_relay_station_n: queue-model scoreboard plus directed scenarios
// for relay_station_n with DATA_WIDTH=8, DEPTH=4, AFULL_THRESH=3.
module tb_relay_station_n;

   localparam int DW  = 8;
   localparam int DEP = 4;
   localparam int AFT = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          ready_s;
   logic          valid_s;
   logic [DW-1:0] data_s;
   logic          ready_m;
   logic          valid_m;
   logic [DW-1:0] data_m;
   logic          afull_s;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] q[$];

   relay_station_n #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEP),
      .AFULL_THRESH(AFT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .ready_s(ready_s),
      .valid_s(valid_s),
      .data_s (data_s),
      .ready_m(ready_m),
      .valid_m(valid_m),
      .data_m (data_m),
      .afull_s(afull_s)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: an ordered queue of accepted words.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else begin
         bit w;
         bit r;
         w = valid_s && (q.size() != DEP);
         r = (q.size() != 0) && ready_m;
         if (r) void'(q.pop_front());
         if (w) q.push_back(data_s);
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_ready_s", 32'(ready_s), 32'd1);
         chk("rst_valid_m", 32'(valid_m), 32'd0);
         chk("rst_afull_s", 32'(afull_s), 32'd0);
      end else begin
         chk("m_ready_s", 32'(ready_s), 32'(q.size() != DEP));
         chk("m_valid_m", 32'(valid_m), 32'(q.size() != 0));
         chk("m_afull_s", 32'(afull_s), 32'(q.size() >= AFT));
         if (q.size() != 0) chk("m_data_m", 32'(data_m), 32'(q[0]));
      end
   end

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      valid_s = 1'b0;
      data_s = '0;
      ready_m = 1'b0;
      #1;
      chk("reset_ready_s", 32'(ready_s), 32'd1);
      chk("reset_valid_m", 32'(valid_m), 32'd0);
      chk("reset_afull_s", 32'(afull_s), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;

      // Single word, latency 1.
      @(negedge clk);
      valid_s = 1'b1; data_s = 8'hA5; ready_m = 1'b1;
      @(negedge clk);
      chk("single_valid", 32'(valid_m), 32'd1);
      chk("single_data", 32'(data_m), 32'hA5);
      valid_s = 1'b0;
      @(negedge clk);
      chk("single_empty", 32'(valid_m), 32'd0);

      // Fill to full with reads blocked.
      ready_m = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         valid_s = 1'b1; data_s = 8'(i);
         @(negedge clk);
         if (i == 3) begin
            chk("fill_afull3", 32'(afull_s), 32'd1);
            chk("fill_ready3", 32'(ready_s), 32'd1);
         end
         if (i == 4) begin
            chk("fill_ready4", 32'(ready_s), 32'd0);
            chk("fill_afull4", 32'(afull_s), 32'd1);
         end
      end
      chk("full_no5th", 32'(ready_s), 32'd0);
      chk("full_head", 32'(data_m), 32'h01);

      // Drain the full buffer.
      valid_s = 1'b0; ready_m = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_data", 32'(data_m), 32'(i));
         chk("drain_valid", 32'(valid_m), 32'd1);
         @(negedge clk);
         if (i == 1) chk("drain_ready_up", 32'(ready_s), 32'd1);
      end
      chk("drain_empty", 32'(valid_m), 32'd0);

      // Streaming 0..19 with no bubbles.
      for (int k = 0; k < 20; k++) begin
         valid_s = 1'b1; data_s = 8'(k);
         @(negedge clk);
         chk("stream_valid", 32'(valid_m), 32'd1);
         chk("stream_data", 32'(data_m), 32'(k));
      end
      valid_s = 1'b0;
      @(negedge clk);
      chk("stream_end", 32'(valid_m), 32'd0);

      // Flush with a concurrent write.
      ready_m = 1'b0;
      valid_s = 1'b1; data_s = 8'h11;
      @(negedge clk);
      data_s = 8'h22;
      @(negedge clk);
      flush = 1'b1; data_s = 8'h77;
      @(negedge clk);
      chk("flush_valid", 32'(valid_m), 32'd0);
      chk("flush_ready", 32'(ready_s), 32'd1);
      chk("flush_afull", 32'(afull_s), 32'd0);
      flush = 1'b0; valid_s = 1'b0; ready_m = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("flush_no77", 32'(valid_m), 32'd0);
      end

      // Asynchronous reset with three words stored.
      ready_m = 1'b0;
      for (int i = 0; i < 3; i++) begin
         valid_s = 1'b1; data_s = 8'(8'h30 + i);
         @(negedge clk);
      end
      valid_s = 1'b0;
      chk("pre_rst_afull", 32'(afull_s), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(valid_m), 32'd0);
      chk("arst_ready", 32'(ready_s), 32'd1);
      chk("arst_afull", 32'(afull_s), 32'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      valid_s = 1'b1; data_s = 8'h5C; ready_m = 1'b1;
      @(negedge clk);
      valid_s = 1'b0;
      chk("post_rst_data", 32'(data_m), 32'h5C);
      chk("post_rst_valid", 32'(valid_m), 32'd1);
      @(negedge clk);

      // Randomized traffic with occasional flush and reset.
      for (int c = 0; c < 3000; c++) begin
         valid_s = ($urandom_range(0, 3) != 0);
         data_s  = 8'($urandom);
         if (c < 1500) ready_m = ($urandom_range(0, 2) == 0);
         else ready_m = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 200) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            #2 rst = 1'b0;
         end
         @(negedge clk);
      end
      valid_s = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
